countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Loadable down-counter: the decrementing counterpart to the team's free-running up-counter; same clock/reset/count interface plus a start/busy/done handshake.
- Counts a programmed value down to zero and pulses done on expiry.
- Optional auto-reload produces periodic ticks.
- Sits beside the up-counter and is driven from the same Ruby-VPI bench infrastructure.

Parameters:
- Size, 5, width of count, load_value and the internal reload register.

Ports:
- clock  input  1  single design clock, all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  capture load_value into reload register and count.
- load_value  input  Size  value captured on load.
- start  input  1  begin countdown from current count (honoured in IDLE only).
- stop  input  1  abort countdown, return to IDLE, count frozen.
- pause  input  1  level; freezes countdown while high.
- auto_reload  input  1  level, sampled at expiry; 1 = reload and keep running.
- count  output  Size  current counter value.
- busy  output  1  high in RUN or HOLD.
- done  output  1  one-cycle pulse at expiry.

Behaviour:
- Reset (synchronous, sampled on posedge clock; overrides every other input):
  - state=IDLE, count=0, reload register=0, busy=0, done=0.
- States: IDLE, RUN, HOLD.
- Input priority each edge: reset > load > stop > start > pause.
- done defaults to 0 every cycle; it is high only in the cycle after an expiry edge.
- load (any state):
  - reload register <= load_value, count <= load_value, state <= IDLE, busy <= 0.
  - A countdown in progress is abandoned; no done pulse.
- stop in RUN/HOLD: state <= IDLE, busy <= 0, count holds its value, no done. stop in IDLE has no effect.
- start in IDLE:
  - count != 0: state <= RUN, busy <= 1. count is unchanged on the start edge; the first decrement happens on the next edge.
  - count == 0: stay IDLE, done pulses for one cycle (immediate expiry), busy stays 0.
  - start in RUN/HOLD is ignored.
- RUN with pause=0, each edge:
  - count > 1: count <= count-1.
  - count == 1, auto_reload=0: count <= 0, done <= 1, state <= IDLE, busy <= 0.
  - count == 1, auto_reload=1: count <= reload register, done <= 1, stay RUN.
  - If the reload register is 1, done pulses every cycle.
- RUN with pause=1: state <= HOLD, count frozen on that edge.
- HOLD: count frozen, busy stays 1. pause=0 returns to RUN; decrementing resumes on the following edge.
- Arithmetic:
  - count never wraps below 0.
  - Unsigned, Size bits; maximum period = 2^Size-1 cycles (31 at default).
- Latency: start at edge N, count==L → done high during the cycle after edge N+L.
- Simultaneous events:
  - load+start: load wins, start dropped.
  - stop+pause: stop wins.
  - Expiry edge with stop: stop wins, no done.
- Reset mid-RUN: returns to reset values on that edge. No done pulse, and the reload value is lost.

Decomposition:
- Shared package counter_pkg:
  - state enum (IDLE, RUN, HOLD).
  - default Size constant (5), shared with the up-counter bench.
- Single module, no sub-module.
- The reload register and next-state logic are small enough to inline.

Test Plan:
- Reset held 3 cycles with load=1, load_value=7 → count=0, busy=0, done=0, reload register 0 (start then gives immediate done).
- load 5, start → busy=1; count runs 5,4,3,2,1,0 on successive edges; done pulses once with count=0; busy drops the same cycle.
- load 3, auto_reload=1, start, run 10 cycles → count 3,2,1,3,2,1,3…; done high every 3rd cycle; busy stays 1.
- load 6, start, pause high 4 cycles when count=4 → count holds 4 for 4 cycles, busy=1, then resumes 3,2,1,0; done once.
- load 9, start; at count=5 assert load with load_value=2 → count=2, state IDLE, busy=0, no done; start again → done after 2 cycles.
- load 0, start → single done pulse, busy never asserts. Separately, load 31, start, stop at count=20 → count holds 20, busy=0, no done.

Source files
------------

// File: rtl/counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the counter family (free-running up-counter and the
// loadable countdown timer).
//   SIZE_DEFAULT : default counter width, shared with the up-counter bench.
//   timer_state_t: countdown timer controller states.
// ----------------------------------------------------------------------------
package counter_pkg;

    localparam int SIZE_DEFAULT = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } timer_state_t;

endpackage : counter_pkg

// File: rtl/countdown_timer.sv
// ----------------------------------------------------------------------------
// countdown_timer
// Loadable down-counter with start/busy/done handshake and optional
// auto-reload for periodic ticks.
//
// Ports
//   clock       : design clock, all state changes on posedge
//   reset       : synchronous active-high reset, overrides every other input
//   load        : capture load_value into reload register and count, go IDLE
//   load_value  : value captured on load
//   start       : begin countdown from current count (IDLE only)
//   stop        : abort countdown, return to IDLE, count frozen
//   pause       : level, freezes countdown while high
//   auto_reload : level, sampled at expiry; 1 = reload and keep running
//   count       : current counter value
//   busy        : high in RUN or HOLD
//   done        : one-cycle pulse in the cycle after an expiry edge
//
// Input priority on each edge: reset > load > stop > start > pause.
// ----------------------------------------------------------------------------
module countdown_timer
    import counter_pkg::*;
#(
    parameter int Size = SIZE_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic [Size-1:0] load_value,
    input  logic            start,
    input  logic            stop,
    input  logic            pause,
    input  logic            auto_reload,
    output logic [Size-1:0] count,
    output logic            busy,
    output logic            done
);

    localparam logic [Size-1:0] COUNT_ZERO = '0;
    localparam logic [Size-1:0] COUNT_ONE  = {{(Size-1){1'b0}}, 1'b1};

    timer_state_t    state_reg,  state_next;
    logic [Size-1:0] count_reg,  count_next;
    logic [Size-1:0] reload_reg, reload_next;
    logic            done_reg,   done_next;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= COUNT_ZERO;
            reload_reg <= COUNT_ZERO;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            reload_reg <= reload_next;
            done_reg   <= done_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        reload_next = reload_reg;
        done_next   = 1'b0;

        if (load) begin
            // Abandons any countdown in progress without a done pulse.
            reload_next = load_value;
            count_next  = load_value;
            state_next  = IDLE;
        end else if (stop && (state_reg != IDLE)) begin
            // Stop beats an expiry on the same edge: count holds, no done.
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (count_reg == COUNT_ZERO) begin
                            // Nothing to count: report immediate expiry.
                            done_next = 1'b1;
                        end else begin
                            // First decrement happens on the following edge.
                            state_next = RUN;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_next = HOLD;
                    end else if (count_reg > COUNT_ONE) begin
                        count_next = count_reg - COUNT_ONE;
                    end else if (count_reg == COUNT_ONE) begin
                        done_next = 1'b1;
                        if (auto_reload) begin
                            count_next = reload_reg;
                        end else begin
                            count_next = COUNT_ZERO;
                            state_next = IDLE;
                        end
                    end else begin
                        // Zero in RUN is unreachable (load keeps count and
                        // reload equal); drop back to IDLE rather than wrap.
                        state_next = IDLE;
                    end
                end
                HOLD: begin
                    // Leaving HOLD costs one edge with count frozen.
                    if (!pause) begin
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign count = count_reg;
    assign busy  = (state_reg != IDLE);
    assign done  = done_reg;

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// ----------------------------------------------------------------------------
// tb_countdown_timer
// Directed bench for countdown_timer. Inputs are driven and outputs sampled
// 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_countdown_timer;

    localparam int W = 5;

    logic         clock;
    logic         reset;
    logic         load;
    logic [W-1:0] load_value;
    logic         start;
    logic         stop;
    logic         pause;
    logic         auto_reload;
    logic [W-1:0] count;
    logic         busy;
    logic         done;

    int tests_run;
    int tests_failed;

    countdown_timer #(.Size(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .load_value  (load_value),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .auto_reload (auto_reload),
        .count       (count),
        .busy        (busy),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge, then settle before sampling / driving.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        load        = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        pause       = 1'b0;
        auto_reload = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b1; load_value = 5'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            $display("[TB] reset cycle %0d: count=%0d busy=%0b done=%0b", i, count, busy, done);
            tests_run++;
            if ({count, busy, done} !== {5'd0, 1'b0, 1'b0}) begin
                tests_failed++;
                $display("FAIL reset_state cycle %0d: got count=%0d busy=%0b done=%0b, want 0/0/0",
                         i, count, busy, done);
            end
        end
        reset = 1'b0; load = 1'b0;
        // Reload register is zero, so start must expire immediately.
        start = 1'b1;
        tick();
        start = 1'b0;
        $display("[TB] start after reset: count=%0d busy=%0b done=%0b", count, busy, done);
        tests_run++;
        if ({count, busy, done} !== {5'd0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_start_done: got count=%0d busy=%0b done=%0b, want 0/0/1", count, busy, done);
        end
        tick();
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_done_one_cycle: got done=%0b, want 0", done);
        end
    endtask

    task automatic test_countdown();
        logic [W-1:0] exp_count [6] = '{5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
        logic         exp_busy  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic         exp_done  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        load = 1'b1; load_value = 5'd5;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            $display("[TB] countdown step %0d: count=%0d busy=%0b done=%0b", i, count, busy, done);
            tests_run++;
            if ({count, busy, done} !== {exp_count[i], exp_busy[i], exp_done[i]}) begin
                tests_failed++;
                $display("FAIL countdown step %0d: got %0d/%0b/%0b, want %0d/%0b/%0b",
                         i, count, busy, done, exp_count[i], exp_busy[i], exp_done[i]);
            end
        end
        tick();
        tests_run++;
        if ({count, busy, done} !== {5'd0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL countdown_settle: got %0d/%0b/%0b, want 0/0/0", count, busy, done);
        end
    endtask

    task automatic test_auto_reload();
        logic [W-1:0] exp_count [10] = '{5'd2, 5'd1, 5'd3, 5'd2, 5'd1, 5'd3, 5'd2, 5'd1, 5'd3, 5'd2};
        logic         exp_done  [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        load = 1'b1; load_value = 5'd3;
        tick();
        load = 1'b0; auto_reload = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if ({count, busy, done} !== {5'd3, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL reload_start: got %0d/%0b/%0b, want 3/1/0", count, busy, done);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            $display("[TB] auto-reload step %0d: count=%0d busy=%0b done=%0b", i, count, busy, done);
            tests_run++;
            if ({count, busy, done} !== {exp_count[i], 1'b1, exp_done[i]}) begin
                tests_failed++;
                $display("FAIL reload step %0d: got %0d/%0b/%0b, want %0d/1/%0b",
                         i, count, busy, done, exp_count[i], exp_done[i]);
            end
        end
        auto_reload = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        tests_run++;
        if ({count, busy, done} !== {5'd2, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reload_stop: got %0d/%0b/%0b, want 2/0/0", count, busy, done);
        end
    endtask

    task automatic test_pause();
        int done_seen;
        logic [W-1:0] exp_count [4] = '{5'd3, 5'd2, 5'd1, 5'd0};
        done_seen = 0;
        load = 1'b1; load_value = 5'd6;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({count, busy} !== {5'd4, 1'b1}) begin
            tests_failed++;
            $display("FAIL pause_pre: got %0d/%0b, want 4/1", count, busy);
        end
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            $display("[TB] pause hold %0d: count=%0d busy=%0b done=%0b", i, count, busy, done);
            tests_run++;
            if ({count, busy, done} !== {5'd4, 1'b1, 1'b0}) begin
                tests_failed++;
                $display("FAIL pause_hold %0d: got %0d/%0b/%0b, want 4/1/0", i, count, busy, done);
            end
        end
        pause = 1'b0;
        // Edge that returns HOLD to RUN keeps the count frozen.
        tick();
        tests_run++;
        if ({count, busy, done} !== {5'd4, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL pause_resume_edge: got %0d/%0b/%0b, want 4/1/0", count, busy, done);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done === 1'b1) done_seen++;
            $display("[TB] pause resume %0d: count=%0d busy=%0b done=%0b", i, count, busy, done);
            tests_run++;
            if (count !== exp_count[i]) begin
                tests_failed++;
                $display("FAIL pause_resume %0d: got count=%0d, want %0d", i, count, exp_count[i]);
            end
        end
        tick();
        if (done === 1'b1) done_seen++;
        tests_run++;
        if (done_seen !== 1) begin
            tests_failed++;
            $display("FAIL pause_done_count: got %0d pulses, want 1", done_seen);
        end
    endtask

    task automatic test_load_override();
        load = 1'b1; load_value = 5'd9;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        tests_run++;
        if (count !== 5'd5) begin
            tests_failed++;
            $display("FAIL override_pre: got count=%0d, want 5", count);
        end
        load = 1'b1; load_value = 5'd2;
        tick();
        load = 1'b0;
        $display("[TB] load override: count=%0d busy=%0b done=%0b", count, busy, done);
        tests_run++;
        if ({count, busy, done} !== {5'd2, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL override_load: got %0d/%0b/%0b, want 2/0/0", count, busy, done);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tests_run++;
        if ({count, busy, done} !== {5'd1, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL override_run: got %0d/%0b/%0b, want 1/1/0", count, busy, done);
        end
        tick();
        tests_run++;
        if ({count, busy, done} !== {5'd0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL override_done: got %0d/%0b/%0b, want 0/0/1", count, busy, done);
        end
    endtask

    task automatic test_zero_and_stop();
        load = 1'b1; load_value = 5'd0;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        $display("[TB] zero start: count=%0d busy=%0b done=%0b", count, busy, done);
        tests_run++;
        if ({count, busy, done} !== {5'd0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL zero_start: got %0d/%0b/%0b, want 0/0/1", count, busy, done);
        end
        tick();
        tests_run++;
        if ({busy, done} !== {1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL zero_after: got busy=%0b done=%0b, want 0/0", busy, done);
        end
        load = 1'b1; load_value = 5'd31;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        tests_run++;
        if ({count, busy} !== {5'd20, 1'b1}) begin
            tests_failed++;
            $display("FAIL stop_pre: got %0d/%0b, want 20/1", count, busy);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        $display("[TB] stop at 20: count=%0d busy=%0b done=%0b", count, busy, done);
        tests_run++;
        if ({count, busy, done} !== {5'd20, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL stop: got %0d/%0b/%0b, want 20/0/0", count, busy, done);
        end
        tick();
        tests_run++;
        if ({count, busy, done} !== {5'd20, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL stop_hold: got %0d/%0b/%0b, want 20/0/0", count, busy, done);
        end
    endtask

    task automatic test_back_to_back();
        // load + start: load wins.
        load = 1'b1; start = 1'b1; load_value = 5'd4;
        tick();
        load = 1'b0; start = 1'b0;
        tests_run++;
        if ({count, busy, done} !== {5'd4, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL load_start: got %0d/%0b/%0b, want 4/0/0", count, busy, done);
        end
        // stop + pause in RUN: stop wins.
        start = 1'b1;
        tick();
        start = 1'b0; stop = 1'b1; pause = 1'b1;
        tick();
        stop = 1'b0; pause = 1'b0;
        tests_run++;
        if ({count, busy, done} !== {5'd4, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL stop_pause: got %0d/%0b/%0b, want 4/0/0", count, busy, done);
        end
        // Stop on the expiry edge: no done, count holds 1.
        load = 1'b1; load_value = 5'd1;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        tests_run++;
        if ({count, busy, done} !== {5'd1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL stop_expiry: got %0d/%0b/%0b, want 1/0/0", count, busy, done);
        end
        // Reload value 1 with auto_reload: done every cycle.
        auto_reload = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            $display("[TB] reload-1 step %0d: count=%0d busy=%0b done=%0b", i, count, busy, done);
            tests_run++;
            if ({count, busy, done} !== {5'd1, 1'b1, 1'b1}) begin
                tests_failed++;
                $display("FAIL reload_one %0d: got %0d/%0b/%0b, want 1/1/1", i, count, busy, done);
            end
        end
        auto_reload = 1'b0;
        // Reset mid-run discards count and reload value.
        load = 1'b1; load_value = 5'd7;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++;
        if ({count, busy, done} !== {5'd0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_midrun: got %0d/%0b/%0b, want 0/0/0", count, busy, done);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if ({count, busy, done} !== {5'd0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_midrun_start: got %0d/%0b/%0b, want 0/0/1", count, busy, done);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        load_value   = '0;
        clear_inputs();
        #2;
        test_reset();
        clear_inputs();
        test_countdown();
        clear_inputs();
        test_auto_reload();
        clear_inputs();
        test_pause();
        clear_inputs();
        test_load_override();
        clear_inputs();
        test_zero_and_stop();
        clear_inputs();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_countdown_timer
